// File: rtl/csv_sfifo_ram.sv
// csv_sfifo_ram: single-clock synchronous FIFO built on a DEPTH x WIDTH RAM.
// Ports:
//   clk          - clock; all state updates on its rising edge
//   resetn       - asynchronous reset, active high (clears pointers and rdata)
//   wdata        - write data, captured on an accepted write
//   i_wreq       - write request (level, sampled each cycle)
//   i_rreq       - read request (level, sampled each cycle)
//   rdata        - registered read data, one cycle after read accept
//   fifo_isempty - FIFO holds no entries
//   fifo_isfull  - FIFO holds DEPTH entries
//   o_wready     - a write would be accepted (!fifo_isfull)
//   o_rready     - a read would be accepted (!fifo_isempty)
module csv_sfifo_ram #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] wdata,
   input  logic             i_wreq,
   input  logic             i_rreq,
   output logic [WIDTH-1:0] rdata,
   output logic             fifo_isempty,
   output logic             fifo_isfull,
   output logic             o_wready,
   output logic             o_rready
);

   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
   localparam int unsigned PTR_WIDTH  = ADDR_WIDTH + 1;

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [PTR_WIDTH-1:0] wptr;
   logic [PTR_WIDTH-1:0] rptr;
   logic                 wr_accept;
   logic                 rd_accept;

   // Status flags decode directly from the registered pointers; the MSB is the wrap bit.
   always_comb begin
      fifo_isempty = (wptr == rptr);
      fifo_isfull  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                     (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
      o_wready     = !fifo_isfull;
      o_rready     = !fifo_isempty;
      wr_accept    = i_wreq && !fifo_isfull;
      rd_accept    = i_rreq && !fifo_isempty;
   end

   // RAM write port; contents are not reset and are only read after being written.
   always_ff @(posedge clk) begin
      if (wr_accept && !resetn) begin
         mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
      end
   end

   // Pointers and registered read data.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         wptr  <= '0;
         rptr  <= '0;
         rdata <= '0;
      end else begin
         if (wr_accept) begin
            wptr <= wptr + PTR_WIDTH'(1);
         end
         if (rd_accept) begin
            rdata <= mem[rptr[ADDR_WIDTH-1:0]];
            rptr  <= rptr + PTR_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_csv_sfifo_ram.sv
module tb_csv_sfifo_ram;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 32;

   logic             clk;
   logic             resetn;
   logic [WIDTH-1:0] wdata;
   logic             i_wreq;
   logic             i_rreq;
   logic [WIDTH-1:0] rdata;
   logic             fifo_isempty;
   logic             fifo_isfull;
   logic             o_wready;
   logic             o_rready;

   csv_sfifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .wdata       (wdata),
      .i_wreq      (i_wreq),
      .i_rreq      (i_rreq),
      .rdata       (rdata),
      .fifo_isempty(fifo_isempty),
      .fifo_isfull (fifo_isfull),
      .o_wready    (o_wready),
      .o_rready    (o_rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: a plain queue of stored words plus the last word read out.
   logic [WIDTH-1:0] q [$];
   logic [WIDTH-1:0] m_rdata = '0;
   logic [WIDTH-1:0] written [$];

   task automatic chk8(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0b expected %0b", name, $time, act, exp);
      end
   endtask

   // Compare every output against the queue model.
   task automatic chk_model();
      chk8("rdata", rdata, m_rdata);
      chk1("empty", fifo_isempty, q.size() == 0);
      chk1("full", fifo_isfull, q.size() == DEPTH);
      chk1("wready", o_wready, q.size() != DEPTH);
      chk1("rready", o_rready, q.size() != 0);
   endtask

   // One clock: drive after the falling edge, update model at the rising edge, check 1ns later.
   task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d);
      bit wa, ra;
      @(negedge clk);
      i_wreq = w;
      i_rreq = r;
      wdata  = d;
      @(posedge clk);
      wa = w && (q.size() < DEPTH);
      ra = r && (q.size() > 0);
      if (ra) m_rdata = q.pop_front();
      if (wa) q.push_back(d);
      #1;
      chk_model();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
   endtask

   task automatic wr(input logic [WIDTH-1:0] d);
      cycle(1'b1, 1'b0, d);
   endtask

   task automatic rd();
      cycle(1'b0, 1'b1, '0);
   endtask

   // Asynchronous reset pulse, 6ns wide, placed mid-cycle with requests active.
   task automatic async_reset();
      @(negedge clk);
      i_wreq = 1'b1;
      i_rreq = 1'b1;
      wdata  = 8'h5A;
      #2 resetn = 1'b1;
      #1;
      chk1("rst_empty", fifo_isempty, 1'b1);
      chk1("rst_full", fifo_isfull, 1'b0);
      chk1("rst_wready", o_wready, 1'b1);
      chk1("rst_rready", o_rready, 1'b0);
      chk8("rst_rdata", rdata, 8'h00);
      #5;
      i_wreq = 1'b0;
      i_rreq = 1'b0;
      resetn = 1'b0;
      q.delete();
      m_rdata = '0;
      idle(1);
      chk1("post_rst_empty", fifo_isempty, 1'b1);
   endtask

   typedef struct {
      logic             w;
      logic             r;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] exp_rdata;
      logic             exp_empty;
      logic             exp_full;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [WIDTH-1:0] v;
      int pw, pr;

      // Hand-derived vectors starting from an empty FIFO.
      vecs[0] = '{1'b1, 1'b0, 8'hAA, 8'h00, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 8'hEE, 8'h00, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 8'hFF, 8'hAA, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 8'h00, 8'hEE, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 8'h11, 8'hFF, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 8'h00, 8'h11, 1'b1, 1'b0};

      resetn = 1'b1;
      i_wreq = 1'b0;
      i_rreq = 1'b0;
      wdata  = '0;
      #1;
      chk1("init_empty", fifo_isempty, 1'b1);
      chk1("init_full", fifo_isfull, 1'b0);
      chk1("init_wready", o_wready, 1'b1);
      chk1("init_rready", o_rready, 1'b0);
      chk8("init_rdata", rdata, 8'h00);
      @(negedge clk);
      #2 resetn = 1'b0;
      idle(1);

      // Table vectors.
      for (int i = 0; i < 8; i++) begin
         cycle(vecs[i].w, vecs[i].r, vecs[i].d);
         chk8("vec_rdata", rdata, vecs[i].exp_rdata);
         chk1("vec_empty", fifo_isempty, vecs[i].exp_empty);
         chk1("vec_full", fifo_isfull, vecs[i].exp_full);
      end

      // Base test: single write/read pairs, then a 3-word burst.
      for (int i = 0; i < 10; i++) begin
         v = WIDTH'($urandom);
         wr(v);
         rd();
         chk8("pair_rdata", rdata, v);
      end
      wr(8'hAA); wr(8'hEE); wr(8'hFF);
      rd(); chk8("burst0", rdata, 8'hAA);
      rd(); chk8("burst1", rdata, 8'hEE);
      rd(); chk8("burst2", rdata, 8'hFF);
      chk1("burst_empty", fifo_isempty, 1'b1);

      // Full test, then a dropped write while full and a full drain.
      written.delete();
      for (int i = 0; i < DEPTH; i++) begin
         v = WIDTH'($urandom);
         written.push_back(v);
         wr(v);
      end
      idle(10);
      chk1("full_flag", fifo_isfull, 1'b1);
      chk1("full_wready", o_wready, 1'b0);
      wr(8'hC3);
      chk1("wfull_wready", o_wready, 1'b0);
      chk1("wfull_full", fifo_isfull, 1'b1);
      // Write plus read while full: write dropped, read proceeds.
      cycle(1'b1, 1'b1, 8'h3C);
      chk8("wfull_rw_rdata", rdata, written[0]);
      chk1("wfull_rw_full", fifo_isfull, 1'b0);
      for (int i = 1; i < DEPTH; i++) begin
         rd();
         chk8("drain", rdata, written[i]);
      end
      chk1("drain_empty", fifo_isempty, 1'b1);

      // Empty test: 31 in, 31 out (pointers now exercise wrap).
      written.delete();
      for (int i = 0; i < DEPTH - 1; i++) begin
         v = WIDTH'($urandom);
         written.push_back(v);
         wr(v);
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         rd();
         chk8("e31", rdata, written[i]);
      end
      idle(10);
      chk1("e31_empty", fifo_isempty, 1'b1);
      chk1("e31_rready", o_rready, 1'b0);

      // Read-when-empty: rdata keeps the 32nd word.
      written.delete();
      for (int i = 0; i < DEPTH; i++) begin
         v = WIDTH'($urandom);
         written.push_back(v);
         wr(v);
      end
      for (int i = 0; i < DEPTH; i++) rd();
      rd();
      chk1("rempty_rready", o_rready, 1'b0);
      chk8("rempty_rdata", rdata, written[DEPTH-1]);

      // Reset test: 10 in, 9 out, asynchronous reset pulse.
      for (int i = 0; i < 10; i++) wr(WIDTH'($urandom));
      for (int i = 0; i < 9; i++) rd();
      async_reset();

      // Randomized traffic with varying write/read bias.
      for (int seg = 0; seg < 12; seg++) begin
         pw = int'($urandom_range(10, 90));
         pr = int'($urandom_range(10, 90));
         for (int i = 0; i < 200; i++) begin
            cycle(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), WIDTH'($urandom));
         end
      end
      async_reset();
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
